// File: rtl/plm_burst_reader_pkg.sv
// plm_pkg: state encoding and read-side constants shared by the PLM burst reader files.
package plm_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;
  localparam int PLM_RD_LAT    = 1;
  localparam int RD_FIFO_DEPTH = 3;
endpackage

// File: rtl/plm_burst_reader_if.sv
// plm_burst_reader_if: command, PLM port and output stream signals of the burst reader.
interface plm_burst_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 13
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] a;
  logic              ce;
  logic              we;
  logic [DATA_W-1:0] wem;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  modport master (
    output start, base_addr, len, q, out_ready,
    input  busy, done, a, ce, we, wem, d, out_data, out_valid
  );
  modport slave (
    input  start, base_addr, len, q, out_ready,
    output busy, done, a, ce, we, wem, d, out_data, out_valid
  );
endinterface

// File: rtl/plm_burst_reader_fifo.sv
// plm_rd_fifo: 3-entry read-data FIFO; simultaneous push and pop keeps occupancy unchanged.
module plm_rd_fifo
  import plm_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count
);
  logic [DATA_W-1:0] r_mem [RD_FIFO_DEPTH];
  logic [1:0]        r_wr, r_rd, r_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr == 2'(RD_FIFO_DEPTH - 1) ? 2'd0 : r_wr + 2'd1;
      end
      if (i_pop) r_rd <= r_rd == 2'(RD_FIFO_DEPTH - 1) ? 2'd0 : r_rd + 2'd1;
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/plm_burst_reader.sv
// plm_burst_reader: reads LEN words from one PLM port starting at BASE_ADDR and streams
// them out in address order on a valid/ready interface, never writing the bank.
module plm_burst_reader
  import plm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 13
) (
  input logic               i_clk,
  input logic               i_rst_n,
  plm_burst_reader_if.slave bus
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len, r_issued, r_accepted;
  logic              r_inflight;
  logic              w_ce, w_pop, w_last, w_valid;
  logic [1:0]        w_occ;
  logic [2:0]        w_outstanding;
  logic [DATA_W-1:0] w_head;
  // Credit: words buffered plus the read whose data returns this cycle must leave room.
  assign w_outstanding = {1'b0, w_occ} + {2'b0, r_inflight};
  assign w_ce    = r_state == ST_RUN && r_issued < r_len && w_outstanding < 3'(RD_FIFO_DEPTH);
  assign w_valid = w_occ != 2'd0;
  assign w_pop   = w_valid && bus.out_ready;
  assign w_last  = w_pop && r_accepted == r_len - LEN_W'(1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = bus.start ? (bus.len != '0 ? ST_RUN : ST_FIN) : ST_IDLE;
      ST_RUN:   w_next = r_issued == r_len ? ST_DRAIN : ST_RUN;
      ST_DRAIN: w_next = w_last ? ST_FIN : ST_DRAIN;
      ST_FIN:   w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_ce;
      if (r_state == ST_IDLE && bus.start) begin
        r_base     <= bus.base_addr;
        r_len      <= bus.len;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_ce) r_issued <= r_issued + LEN_W'(1);
        if (w_pop) r_accepted <= r_accepted + LEN_W'(1);
      end
    end
  plm_rd_fifo #(.DATA_W(DATA_W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (bus.q),
    .o_head  (w_head),
    .o_count (w_occ)
  );
  assign bus.a         = r_base + r_issued[ADDR_W-1:0];
  assign bus.ce        = w_ce;
  assign bus.we        = 1'b0;
  assign bus.wem       = '0;
  assign bus.d         = '0;
  assign bus.out_data  = w_head;
  assign bus.out_valid = w_valid;
  assign bus.busy      = r_state == ST_RUN || r_state == ST_DRAIN;
  assign bus.done      = r_state == ST_FIN;
endmodule

// File: tb/tb_plm_burst_reader.sv
// tb_plm_burst_reader: directed and random-backpressure checks of plm_burst_reader against a
// PLM model holding word[a] = a[3:0].
module tb_plm_burst_reader;
  localparam int AW = 12;
  localparam int DW = 4;
  localparam int LW = 13;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int ce_cnt = 0;
  int hs_cnt = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_q[$];
  plm_burst_reader_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
  plm_burst_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.ce) bus.q <= bus.a[3:0];
  // Continuous checks: constant write side, outstanding bound, hold under stall, stream order.
  always @(negedge clk) begin
    if (!rst_n) begin
      ce_cnt = 0;
      hs_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      n_cmp++;
      if (bus.we !== 1'b0 || bus.wem !== '0 || bus.d !== '0) begin
        n_err++;
        $display("FAIL write_side: we=%b wem=%h d=%h, want all 0", bus.we, bus.wem, bus.d);
      end
      if (bus.ce) begin
        n_cmp++;
        if (ce_cnt - hs_cnt >= 3) begin
          n_err++;
          $display("FAIL credit: ce with %0d outstanding, want < 3", ce_cnt - hs_cnt);
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          n_err++;
          $display("FAIL hold: valid=%b data=%h, want valid=1 data=%h", bus.out_valid, bus.out_data, prev_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stream: extra word %h, want none", bus.out_data);
        end else if (bus.out_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL stream: data=%h, want %h", bus.out_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hs_cnt++;
      end
      if (bus.ce) ce_cnt++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic start_burst(input logic [AW-1:0] base, input logic [LW-1:0] len);
    logic [AW-1:0] ad;
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.len = len;
    for (int i = 0; i < int'(len); i++) begin
      ad = base + AW'(i);
      exp_q.push_back(ad[3:0]);
    end
    tick;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int limit, input bit rnd);
    bit seen;
    int cyc;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < limit) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.done) seen = 1'b1;
      else begin
        tick;
        cyc++;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: no DONE in %0d cycles, want DONE", limit);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL words_left: %0d undelivered, want 0", exp_q.size());
    end
    tick;
  endtask
  task automatic test_reset;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;
    bus.out_ready = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({bus.busy, bus.done, bus.ce, bus.out_valid} !== 4'b0 || bus.a !== '0 || bus.out_data !== '0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b ce=%b valid=%b a=%h data=%h, want all 0",
               bus.busy, bus.done, bus.ce, bus.out_valid, bus.a, bus.out_data);
    end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_basic;
    bus.out_ready = 1'b1;
    start_burst(12'h010, 13'd4);
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if (bus.ce !== (k <= 4)) begin
        n_err++;
        $display("FAIL basic_ce t+%0d: ce=%b, want %b", k, bus.ce, k <= 4);
      end
      if (k <= 4) begin
        n_cmp++;
        if (bus.a !== AW'(32'h10 + k - 1)) begin
          n_err++;
          $display("FAIL basic_a t+%0d: a=%h, want %h", k, bus.a, AW'(32'h10 + k - 1));
        end
      end
      n_cmp++;
      if (bus.out_valid !== (k >= 3 && k <= 6)) begin
        n_err++;
        $display("FAIL basic_valid t+%0d: valid=%b, want %b", k, bus.out_valid, k >= 3 && k <= 6);
      end
      if (k >= 3 && k <= 6) begin
        n_cmp++;
        if (bus.out_data !== DW'(k - 3)) begin
          n_err++;
          $display("FAIL basic_data t+%0d: data=%h, want %h", k, bus.out_data, DW'(k - 3));
        end
      end
      n_cmp++;
      if (bus.done !== (k == 7) || bus.busy !== (k <= 6)) begin
        n_err++;
        $display("FAIL basic_done t+%0d: done=%b busy=%b, want %b %b", k, bus.done, bus.busy, k == 7, k <= 6);
      end
      tick;
    end
  endtask
  task automatic test_wrap;
    logic [AW-1:0] ea[4];
    ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    bus.out_ready = 1'b1;
    start_burst(12'hFFE, 13'd4);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) begin
        n_cmp++;
        if (bus.ce !== 1'b1 || bus.a !== ea[k-1]) begin
          n_err++;
          $display("FAIL wrap_a t+%0d: ce=%b a=%h, want 1 %h", k, bus.ce, bus.a, ea[k-1]);
        end
      end
      if (k >= 3) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== ea[k-3][3:0]) begin
          n_err++;
          $display("FAIL wrap_data t+%0d: valid=%b data=%h, want 1 %h", k, bus.out_valid, bus.out_data, ea[k-3][3:0]);
        end
      end
      tick;
    end
    wait_done(4, 1'b0);
  endtask
  task automatic test_backpressure;
    bit pat[4];
    int got;
    bit seen;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    got = 0;
    seen = 1'b0;
    start_burst(12'h100, 13'd8);
    for (int k = 1; k <= 60 && !seen; k++) begin
      bus.out_ready = pat[(k - 1) % 4];
      if (bus.done) seen = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (bus.out_data !== DW'(got)) begin
          n_err++;
          $display("FAIL bp_order word %0d: data=%h, want %h", got, bus.out_data, DW'(got));
        end
        got++;
      end
      tick;
    end
    n_cmp++;
    if (!seen || got != 8) begin
      n_err++;
      $display("FAIL bp_count: done=%b words=%0d, want 1 8", seen, got);
    end
    bus.out_ready = 1'b1;
  endtask
  task automatic test_len_zero;
    int ce0;
    int got;
    bus.out_ready = 1'b1;
    start_burst(12'h123, 13'd0);
    n_cmp++;
    if ({bus.done, bus.busy, bus.ce, bus.out_valid} !== 4'b1000) begin
      n_err++;
      $display("FAIL len0 t+1: done=%b busy=%b ce=%b valid=%b, want 1 0 0 0", bus.done, bus.busy, bus.ce, bus.out_valid);
    end
    tick;
    n_cmp++;
    if ({bus.done, bus.busy, bus.ce, bus.out_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL len0 t+2: done=%b busy=%b ce=%b valid=%b, want 0 0 0 0", bus.done, bus.busy, bus.ce, bus.out_valid);
    end
    ce0 = ce_cnt;
    got = hs_cnt;
    start_burst(12'h200, 13'd5);
    tick;
    bus.start = 1'b1;
    bus.base_addr = 12'h007;
    bus.len = 13'd3;
    tick;
    bus.start = 1'b0;
    wait_done(30, 1'b0);
    n_cmp++;
    if (ce_cnt - ce0 != 5 || hs_cnt - got != 5 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_start: ce=%0d words=%0d busy=%b, want 5 5 0", ce_cnt - ce0, hs_cnt - got, bus.busy);
    end
  endtask
  task automatic test_reset_mid;
    int got;
    got = 0;
    bus.out_ready = 1'b1;
    start_burst(12'h040, 13'd6);
    for (int k = 1; k <= 20 && got < 2; k++) begin
      if (bus.out_valid) got++;
      if (got < 2) tick;
    end
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.ce, bus.out_valid} !== 4'b0 || bus.a !== '0 || bus.out_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b ce=%b valid=%b a=%h data=%h, want all 0",
               bus.busy, bus.done, bus.ce, bus.out_valid, bus.a, bus.out_data);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: done=%b busy=%b, want 0 0", bus.done, bus.busy);
      end
    end
    rst_n = 1'b1;
    tick;
    start_burst(12'h3FD, 13'd3);
    wait_done(20, 1'b0);
  endtask
  task automatic test_full_bank;
    int ce0;
    ce0 = ce_cnt;
    bus.out_ready = 1'b1;
    start_burst(12'h555, 13'd4096);
    wait_done(5000, 1'b0);
    n_cmp++;
    if (ce_cnt - ce0 != 4096) begin
      n_err++;
      $display("FAIL full_bank: ce count=%0d, want 4096", ce_cnt - ce0);
    end
  endtask
  task automatic test_random;
    int unsigned len;
    for (int b = 0; b < 1000; b++) begin
      len = $urandom_range(0, 9);
      start_burst(AW'($urandom), LW'(len));
      wait_done(int'(len) * 8 + 20, 1'b1);
    end
    bus.out_ready = 1'b1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_len_zero;
    test_reset_mid;
    test_full_bank;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
